// File: rtl/encoder_pkg.sv
// Shared types and constants for the rotary-encoder parameter controller.
// UI state encodings and the unaccelerated step size.
package encoder_pkg;

    typedef enum logic [1:0] {
        HOME   = 2'd0,
        SELECT = 2'd1,
        EDIT   = 2'd2
    } UiState;

    localparam logic [1:0] UI_HOME   = 2'd0;
    localparam logic [1:0] UI_SELECT = 2'd1;
    localparam logic [1:0] UI_EDIT   = 2'd2;

    localparam int NORMAL_STEP = 1;

endpackage

// File: rtl/param_step_sat.sv
// Saturating step of one parameter value, up or down.
// Pure combinational; flags whether the value actually moved.
module param_step_sat #(
    parameter int VALUE_W   = 8,
    parameter int MAX_VALUE = 255
) (
    input  logic [VALUE_W-1:0] old_value,
    input  logic [VALUE_W-1:0] step,
    input  logic               clockwise,
    output logic [VALUE_W-1:0] new_value,
    output logic               changed
);

    localparam logic [VALUE_W:0] MAX_EXT = MAX_VALUE[VALUE_W:0];

    logic [VALUE_W:0] sum_w;
    logic [VALUE_W:0] diff_w;

    // One extra bit catches both overflow and borrow before clamping.
    always_comb begin
        sum_w     = {1'b0, old_value} + {1'b0, step};
        diff_w    = {1'b0, old_value} - {1'b0, step};
        new_value = old_value;
        if (clockwise) begin
            if (sum_w > MAX_EXT) begin
                new_value = MAX_EXT[VALUE_W-1:0];
            end else begin
                new_value = sum_w[VALUE_W-1:0];
            end
        end else begin
            if (diff_w[VALUE_W]) begin
                new_value = '0;
            end else if (diff_w > MAX_EXT) begin
                new_value = MAX_EXT[VALUE_W-1:0];
            end else begin
                new_value = diff_w[VALUE_W-1:0];
            end
        end
        changed = (new_value != old_value);
    end

endmodule

// File: rtl/encoder_param_controller.sv
// HOME/SELECT/EDIT controller for a bank of encoder-driven parameters.
// Accelerated saturating steps, inactivity timeout, registered update strobe.
module encoder_param_controller
    import encoder_pkg::*;
#(
    parameter int NUM_PARAMS     = 4,
    parameter int VALUE_W        = 8,
    parameter int MAX_VALUE      = 255,
    parameter int DEFAULT_VALUE  = 128,
    parameter int ACCEL_WINDOW   = 2_000_000,
    parameter int ACCEL_STEP     = 4,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    localparam int IDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               click_stb,
    input  logic               clockwise,
    input  logic               switch_stb,
    output logic [1:0]         ui_state,
    output logic [IDX_W-1:0]   sel_index,
    output logic               param_update_stb,
    output logic [IDX_W-1:0]   param_index,
    output logic [VALUE_W-1:0] param_value,
    input  logic [IDX_W-1:0]   rd_index,
    output logic [VALUE_W-1:0] rd_value
);

    localparam int TMR_W = $clog2(ACCEL_WINDOW + 2);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TMR_W-1:0]   TMR_SAT   = TMR_W'(ACCEL_WINDOW + 1);
    localparam logic [TMR_W-1:0]   TMR_WIN   = TMR_W'(ACCEL_WINDOW);
    localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [VALUE_W-1:0] STEP_FAST = VALUE_W'(ACCEL_STEP);
    localparam logic [VALUE_W-1:0] STEP_NORM = VALUE_W'(NORMAL_STEP);
    localparam logic [VALUE_W-1:0] DEF_VAL   = VALUE_W'(DEFAULT_VALUE);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_PARAMS - 1);

    UiState             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [VALUE_W-1:0] params_q [NUM_PARAMS];
    logic [VALUE_W-1:0] params_d [NUM_PARAMS];
    logic               stb_q, stb_d;
    logic [IDX_W-1:0]   pidx_q, pidx_d;
    logic [VALUE_W-1:0] pval_q, pval_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               dir_q, dir_d;
    logic [TO_W-1:0]    to_q, to_d;

    logic               click_ok;
    logic               fast;
    logic [VALUE_W-1:0] step;
    logic [IDX_W-1:0]   tgt_idx;
    logic [VALUE_W-1:0] old_value;
    logic [VALUE_W-1:0] new_value;
    logic               changed;

    // Pick the target parameter and the step size for this click.
    always_comb begin
        click_ok  = click_stb && !switch_stb;
        fast      = (dir_q == clockwise) && (tmr_q <= TMR_WIN);
        step      = fast ? STEP_FAST : STEP_NORM;
        tgt_idx   = (state_q == EDIT) ? sel_q : '0;
        old_value = params_q[tgt_idx];
    end

    param_step_sat #(
        .VALUE_W   (VALUE_W),
        .MAX_VALUE (MAX_VALUE)
    ) u_step (
        .old_value (old_value),
        .step      (step),
        .clockwise (clockwise),
        .new_value (new_value),
        .changed   (changed)
    );

    // UI state machine, parameter writes, acceleration and timeout.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        params_d = params_q;
        stb_d    = 1'b0;
        pidx_d   = pidx_q;
        pval_d   = pval_q;
        dir_d    = dir_q;
        to_d     = to_q;
        tmr_d    = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + 1'b1;

        if (click_ok) begin
            tmr_d = TMR_ONE;
            dir_d = clockwise;
        end

        unique case (state_q)
            HOME: begin
                if (switch_stb) begin
                    state_d = SELECT;
                    sel_d   = '0;
                end else if (click_ok && changed) begin
                    params_d[tgt_idx] = new_value;
                    stb_d  = 1'b1;
                    pidx_d = tgt_idx;
                    pval_d = new_value;
                end
            end
            SELECT: begin
                if (switch_stb) begin
                    state_d = EDIT;
                end else if (click_ok) begin
                    if (clockwise) begin
                        sel_d = (sel_q == IDX_LAST) ? '0 : sel_q + 1'b1;
                    end else begin
                        sel_d = (sel_q == '0) ? IDX_LAST : sel_q - 1'b1;
                    end
                end
            end
            EDIT: begin
                if (switch_stb) begin
                    state_d = SELECT;
                end else if (click_ok && changed) begin
                    params_d[tgt_idx] = new_value;
                    stb_d  = 1'b1;
                    pidx_d = tgt_idx;
                    pval_d = new_value;
                end
            end
            default: state_d = HOME;
        endcase

        if (state_q == HOME) begin
            to_d = '0;
        end else if (click_stb || switch_stb) begin
            to_d = '0;
        end else if (to_q == TO_LAST) begin
            to_d    = '0;
            state_d = HOME;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    // State and bank registers; reset wins over every strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HOME;
            sel_q   <= '0;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                params_q[i] <= DEF_VAL;
            end
            stb_q  <= 1'b0;
            pidx_q <= '0;
            pval_q <= '0;
            tmr_q  <= TMR_SAT;
            dir_q  <= 1'b0;
            to_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            params_q <= params_d;
            stb_q    <= stb_d;
            pidx_q   <= pidx_d;
            pval_q   <= pval_d;
            tmr_q    <= tmr_d;
            dir_q    <= dir_d;
            to_q     <= to_d;
        end
    end

    // Combinational readback; out-of-range addresses read as zero.
    always_comb begin
        rd_value = '0;
        if (32'(rd_index) < NUM_PARAMS) begin
            rd_value = params_q[rd_index];
        end
    end

    assign ui_state         = state_q;
    assign sel_index        = sel_q;
    assign param_update_stb = stb_q;
    assign param_index      = pidx_q;
    assign param_value      = pval_q;

endmodule

// File: tb/tb_encoder_param_controller.sv
// Directed bench for encoder_param_controller.
// Short acceleration window and timeout keep the run small.
module tb_encoder_param_controller;

    localparam int NP = 4;
    localparam int VW = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          click_stb = 1'b0;
    logic          clockwise = 1'b0;
    logic          switch_stb = 1'b0;
    logic [1:0]    ui_state;
    logic [IW-1:0] sel_index;
    logic          param_update_stb;
    logic [IW-1:0] param_index;
    logic [VW-1:0] param_value;
    logic [IW-1:0] rd_index = '0;
    logic [VW-1:0] rd_value;

    int errors = 0;
    int checks = 0;

    encoder_param_controller #(
        .NUM_PARAMS     (NP),
        .VALUE_W        (VW),
        .MAX_VALUE      (255),
        .DEFAULT_VALUE  (128),
        .ACCEL_WINDOW   (10),
        .ACCEL_STEP     (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .click_stb        (click_stb),
        .clockwise        (clockwise),
        .switch_stb       (switch_stb),
        .ui_state         (ui_state),
        .sel_index        (sel_index),
        .param_update_stb (param_update_stb),
        .param_index      (param_index),
        .param_value      (param_value),
        .rd_index         (rd_index),
        .rd_value         (rd_value)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_click(input logic dir);
        @(negedge clk);
        click_stb = 1'b1;
        clockwise = dir;
        @(posedge clk);
        #1;
        click_stb = 1'b0;
    endtask

    task automatic do_switch();
        @(negedge clk);
        switch_stb = 1'b1;
        @(posedge clk);
        #1;
        switch_stb = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        checks++;
        if (ui_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_state: got %0d want 0", ui_state);
        end
        checks++;
        if (sel_index !== 2'd0) begin
            errors++;
            $display("FAIL rst_sel: got %0d want 0", sel_index);
        end
        checks++;
        if (param_update_stb !== 1'b0 || param_index !== 2'd0
            || param_value !== 8'd0) begin
            errors++;
            $display("FAIL rst_out: got stb=%0b idx=%0d val=%0d want 0/0/0",
                     param_update_stb, param_index, param_value);
        end
        for (int i = 0; i < NP; i++) begin
            rd_index = IW'(i);
            #1;
            checks++;
            if (rd_value !== 8'd128) begin
                errors++;
                $display("FAIL rst_param%0d: got %0d want 128", i, rd_value);
            end
        end
        rd_index = '0;
    endtask

    task automatic test_slow_home();
        for (int k = 1; k <= 3; k++) begin
            idle(20);
            do_click(1'b1);
            checks++;
            if (param_update_stb !== 1'b1 || param_index !== 2'd0
                || param_value !== VW'(128 + k)) begin
                errors++;
                $display("FAIL slow%0d: got stb=%0b idx=%0d val=%0d want 1/0/%0d",
                         k, param_update_stb, param_index, param_value, 128 + k);
            end
            idle(1);
            checks++;
            if (param_update_stb !== 1'b0) begin
                errors++;
                $display("FAIL slow%0d_drop: got stb=%0b want 0",
                         k, param_update_stb);
            end
        end
    endtask

    task automatic test_fast_home();
        logic [VW-1:0] exp_v [5];
        logic          dirs  [5];
        exp_v = '{8'd132, 8'd136, 8'd140, 8'd139, 8'd135};
        dirs  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        idle(20);
        for (int k = 0; k < 5; k++) begin
            do_click(dirs[k]);
            checks++;
            if (param_update_stb !== 1'b1 || param_value !== exp_v[k]) begin
                errors++;
                $display("FAIL fast%0d: got stb=%0b val=%0d want 1/%0d",
                         k, param_update_stb, param_value, exp_v[k]);
            end
        end
    endtask

    task automatic test_saturation();
        idle(20);
        do_click(1'b1);
        repeat (29) do_click(1'b1);
        idle(20);
        do_click(1'b1);
        idle(20);
        do_click(1'b1);
        checks++;
        if (rd_value !== 8'd254) begin
            errors++;
            $display("FAIL hi_pre: got %0d want 254", rd_value);
        end
        do_click(1'b1);
        checks++;
        if (param_update_stb !== 1'b1 || param_value !== 8'd255) begin
            errors++;
            $display("FAIL hi_clamp: got stb=%0b val=%0d want 1/255",
                     param_update_stb, param_value);
        end
        for (int k = 0; k < 2; k++) begin
            do_click(1'b1);
            checks++;
            if (param_update_stb !== 1'b0 || rd_value !== 8'd255) begin
                errors++;
                $display("FAIL hi_quiet%0d: got stb=%0b rd=%0d want 0/255",
                         k, param_update_stb, rd_value);
            end
        end
        idle(20);
        do_click(1'b0);
        repeat (63) do_click(1'b0);
        idle(20);
        do_click(1'b0);
        checks++;
        if (rd_value !== 8'd1 || param_value !== 8'd1) begin
            errors++;
            $display("FAIL lo_pre: got rd=%0d val=%0d want 1/1",
                     rd_value, param_value);
        end
        do_click(1'b0);
        checks++;
        if (param_update_stb !== 1'b1 || param_value !== 8'd0) begin
            errors++;
            $display("FAIL lo_clamp: got stb=%0b val=%0d want 1/0",
                     param_update_stb, param_value);
        end
        for (int k = 0; k < 2; k++) begin
            do_click(1'b0);
            checks++;
            if (param_update_stb !== 1'b0 || rd_value !== 8'd0
                || param_value !== 8'd0) begin
                errors++;
                $display("FAIL lo_quiet%0d: got stb=%0b rd=%0d val=%0d want 0/0/0",
                         k, param_update_stb, rd_value, param_value);
            end
        end
    endtask

    task automatic test_select_edit();
        logic [IW-1:0] exp_sel [5];
        exp_sel = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        do_switch();
        checks++;
        if (ui_state !== 2'd1 || sel_index !== 2'd0
            || param_update_stb !== 1'b0) begin
            errors++;
            $display("FAIL to_select: got st=%0d sel=%0d stb=%0b want 1/0/0",
                     ui_state, sel_index, param_update_stb);
        end
        for (int k = 0; k < 5; k++) begin
            do_click(1'b0);
            checks++;
            if (sel_index !== exp_sel[k] || param_update_stb !== 1'b0) begin
                errors++;
                $display("FAIL sel%0d: got sel=%0d stb=%0b want %0d/0",
                         k, sel_index, param_update_stb, exp_sel[k]);
            end
        end
        do_switch();
        checks++;
        if (ui_state !== 2'd2) begin
            errors++;
            $display("FAIL to_edit: got %0d want 2", ui_state);
        end
        do_click(1'b1);
        checks++;
        if (param_update_stb !== 1'b1 || param_index !== 2'd3
            || param_value !== 8'd129) begin
            errors++;
            $display("FAIL edit3: got stb=%0b idx=%0d val=%0d want 1/3/129",
                     param_update_stb, param_index, param_value);
        end
        rd_index = 2'd0;
        #1;
        checks++;
        if (rd_value !== 8'd0) begin
            errors++;
            $display("FAIL edit_p0: got %0d want 0", rd_value);
        end
    endtask

    task automatic test_timeout();
        idle(99);
        checks++;
        if (ui_state !== 2'd2) begin
            errors++;
            $display("FAIL to_early: got %0d want 2", ui_state);
        end
        idle(1);
        checks++;
        if (ui_state !== 2'd0) begin
            errors++;
            $display("FAIL to_home: got %0d want 0", ui_state);
        end
    endtask

    task automatic test_click_and_switch();
        @(negedge clk);
        click_stb  = 1'b1;
        clockwise  = 1'b1;
        switch_stb = 1'b1;
        @(posedge clk);
        #1;
        click_stb  = 1'b0;
        switch_stb = 1'b0;
        rd_index   = 2'd0;
        #1;
        checks++;
        if (ui_state !== 2'd1 || param_update_stb !== 1'b0
            || rd_value !== 8'd0 || sel_index !== 2'd0) begin
            errors++;
            $display("FAIL both: got st=%0d stb=%0b p0=%0d sel=%0d want 1/0/0/0",
                     ui_state, param_update_stb, rd_value, sel_index);
        end
    endtask

    task automatic test_reset_mid_edit();
        do_switch();
        checks++;
        if (ui_state !== 2'd2) begin
            errors++;
            $display("FAIL pre_rst: got %0d want 2", ui_state);
        end
        @(negedge clk);
        reset     = 1'b1;
        click_stb = 1'b1;
        clockwise = 1'b1;
        @(posedge clk);
        #1;
        click_stb = 1'b0;
        reset     = 1'b0;
        checks++;
        if (ui_state !== 2'd0 || param_update_stb !== 1'b0
            || param_value !== 8'd0 || param_index !== 2'd0) begin
            errors++;
            $display("FAIL mid_rst: got st=%0d stb=%0b idx=%0d val=%0d want 0/0/0/0",
                     ui_state, param_update_stb, param_index, param_value);
        end
        for (int i = 0; i < NP; i++) begin
            rd_index = IW'(i);
            #1;
            checks++;
            if (rd_value !== 8'd128) begin
                errors++;
                $display("FAIL mid_rst_p%0d: got %0d want 128", i, rd_value);
            end
        end
        do_click(1'b1);
        checks++;
        if (param_update_stb !== 1'b1 || param_value !== 8'd129) begin
            errors++;
            $display("FAIL post_rst: got stb=%0b val=%0d want 1/129",
                     param_update_stb, param_value);
        end
    endtask

    initial begin
        test_reset();
        test_slow_home();
        test_fast_home();
        test_saturation();
        test_select_edit();
        test_timeout();
        test_click_and_switch();
        test_reset_mid_edit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
